// File: rtl/pwr_domain_scheduler_if.sv
// Handshake/status bundle between the power-domain scheduler and its
// environment (supply sequencer, domain switches, safety manager).
//   master : environment side, drives requests, power-good and config
//   slave  : scheduler side, drives enables, status and safe-state request
interface pwr_domain_scheduler_if #(
   parameter int N_DOM = 4,
   parameter int CNT_W = 16
);
   logic                sched_en;
   logic                vdd_fault;
   logic                fault_clr;
   logic [N_DOM-1:0]    dom_req;
   logic [N_DOM-1:0]    dom_pgood;
   logic [CNT_W-1:0]    timeout_cycles;
   logic [CNT_W-1:0]    settle_cycles;
   logic [N_DOM-1:0]    dom_en;
   logic [N_DOM-1:0]    dom_active;
   logic [N_DOM-1:0]    dom_fault;
   logic                safe_state_req;
   logic                busy;
   logic [2:0]          fsm_state;

   modport master (
      output sched_en, vdd_fault, fault_clr, dom_req, dom_pgood,
             timeout_cycles, settle_cycles,
      input  dom_en, dom_active, dom_fault, safe_state_req, busy, fsm_state
   );

   modport slave (
      input  sched_en, vdd_fault, fault_clr, dom_req, dom_pgood,
             timeout_cycles, settle_cycles,
      output dom_en, dom_active, dom_fault, safe_state_req, busy, fsm_state
   );
endinterface

// File: rtl/pwr_domain_scheduler.sv
// Power-domain scheduler: grants one switchable domain at a time on a shared
// inrush-limited rail, waits for its power-good with timeout/retry/settle,
// tracks sticky per-domain faults and requests safe state on rail fault or
// on brownout of an already active domain.
//
// Build option: define PWR_SCHED_FIXED_PRIO_EN for fixed priority arbitration
// (lowest index wins, no round-robin pointer). Default is round-robin.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for an eligible request, at most one grant per visit
// RAMP      | switch of granted domain on, waiting for its power-good
// SETTLE    | power-good seen, must hold settle_cycles before active
// RETRY_OFF | one-cycle switch-off between failed ramp and next attempt
// SAFE      | rail fault or brownout; no grants until fault_clr
module pwr_domain_scheduler #(
   parameter int N_DOM     = 4,
   parameter int CNT_W     = 16,
   parameter int MAX_RETRY = 2
) (
   input logic                    clk,
   input logic                    reset,
   pwr_domain_scheduler_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RAMP      = 3'd1,
      SETTLE    = 3'd2,
      RETRY_OFF = 3'd3,
      SAFE      = 3'd4
   } state_t;

   localparam int                IDX_W   = $clog2(N_DOM);
   localparam int                RTY_W   = $clog2(MAX_RETRY + 2);
   localparam logic [RTY_W-1:0]  RTY_MAX = RTY_W'(MAX_RETRY);
   localparam logic [IDX_W:0]    N_DOM_W = (IDX_W + 1)'(N_DOM);
   localparam logic [IDX_W-1:0]  LAST_IX = IDX_W'(N_DOM - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    g_q, g_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    tmo_q, tmo_d;
   logic [CNT_W-1:0]    stl_q, stl_d;
   logic [RTY_W-1:0]    retry_q, retry_d;
   logic [N_DOM-1:0]    en_q, en_d;
   logic [N_DOM-1:0]    act_q, act_d;
   logic [N_DOM-1:0]    flt_q, flt_d;
   logic                safe_q, safe_d;
   logic                busy_q, busy_d;
`ifndef PWR_SCHED_FIXED_PRIO_EN
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W:0]      cand_sum;
`endif

   logic [N_DOM-1:0]    eligible;
   logic [N_DOM-1:0]    drop;
   logic [N_DOM-1:0]    brown;
   logic                pick_vld;
   logic [IDX_W-1:0]    pick_idx;
   logic [IDX_W-1:0]    cand;
   logic                fail_s;

   assign eligible = bus.dom_req & ~en_q & ~flt_q;
   assign drop     = en_q & ~bus.dom_req;
   assign brown    = act_q & ~bus.dom_pgood;

   // Arbiter: scan candidates from highest to lowest rank so the best one is
   // assigned last (rank 0 is ptr_q in round-robin, index 0 in fixed mode).
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
`ifndef PWR_SCHED_FIXED_PRIO_EN
      cand_sum = '0;
`endif
      for (int k = N_DOM - 1; k >= 0; k--) begin
`ifdef PWR_SCHED_FIXED_PRIO_EN
         cand = IDX_W'(k);
`else
         cand_sum = {1'b0, ptr_q} + (IDX_W + 1)'(k);
         if (cand_sum >= N_DOM_W) begin
            cand_sum = cand_sum - N_DOM_W;
         end
         cand = cand_sum[IDX_W-1:0];
`endif
         if (eligible[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   // Next-state logic in priority order: rail fault, brownout, SAFE exit,
   // then request drops, grant progress and new grants.
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      stl_d   = stl_q;
      retry_d = retry_q;
      en_d    = en_q;
      act_d   = act_q;
      flt_d   = flt_q;
      fail_s  = 1'b0;
`ifndef PWR_SCHED_FIXED_PRIO_EN
      ptr_d   = ptr_q;
`endif
      if (bus.vdd_fault) begin
         state_d = SAFE;
         en_d    = '0;
         act_d   = '0;
      end else if (brown != '0) begin
         en_d  = en_q & ~brown;
         act_d = act_q & ~brown;
         if (state_q != SAFE) begin
            en_d  = en_d & ~drop;
            act_d = act_d & ~drop;
            if (bus.fault_clr) begin
               flt_d = '0;
            end
         end
         flt_d   = flt_d | brown;
         state_d = SAFE;
      end else if (state_q == SAFE) begin
         if (bus.fault_clr) begin
            flt_d   = '0;
            state_d = IDLE;
         end
      end else begin
         en_d  = en_q & ~drop;
         act_d = act_q & ~drop;
         if (bus.fault_clr) begin
            flt_d = '0;
         end
         case (state_q)
            IDLE: begin
               if (bus.sched_en && pick_vld) begin
                  g_d            = pick_idx;
                  en_d[pick_idx] = 1'b1;
                  cnt_d          = '0;
                  retry_d        = '0;
                  tmo_d          = bus.timeout_cycles;
                  stl_d          = bus.settle_cycles;
                  state_d        = RAMP;
`ifndef PWR_SCHED_FIXED_PRIO_EN
                  ptr_d          = (pick_idx == LAST_IX) ? '0 : pick_idx + 1'b1;
`endif
               end
            end
            RAMP: begin
               if (!bus.dom_req[g_q]) begin
                  state_d = IDLE;
               end else if (bus.dom_pgood[g_q]) begin
                  cnt_d   = '0;
                  state_d = SETTLE;
               end else if (cnt_q == tmo_q) begin
                  fail_s = 1'b1;
               end else begin
                  cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
               end
            end
            SETTLE: begin
               if (!bus.dom_req[g_q]) begin
                  state_d = IDLE;
               end else if (!bus.dom_pgood[g_q]) begin
                  fail_s = 1'b1;
               end else if (cnt_q == stl_q) begin
                  act_d[g_q] = 1'b1;
                  state_d    = IDLE;
               end else begin
                  cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
               end
            end
            RETRY_OFF: begin
               if (!bus.dom_req[g_q]) begin
                  state_d = IDLE;
               end else begin
                  en_d[g_q] = 1'b1;
                  cnt_d     = '0;
                  state_d   = RAMP;
               end
            end
            default: begin
               state_d = SAFE;
               en_d    = '0;
               act_d   = '0;
            end
         endcase
         if (fail_s) begin
            en_d[g_q] = 1'b0;
            if (retry_q < RTY_MAX) begin
               retry_d = retry_q + 1'b1;
               state_d = RETRY_OFF;
            end else begin
               flt_d[g_q] = 1'b1;
               state_d    = IDLE;
            end
         end
      end
      safe_d = (state_d == SAFE);
      busy_d = (state_d == RAMP) || (state_d == SETTLE) || (state_d == RETRY_OFF);
   end

   // State and output registers, synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         g_q     <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
         stl_q   <= '0;
         retry_q <= '0;
         en_q    <= '0;
         act_q   <= '0;
         flt_q   <= '0;
         safe_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifndef PWR_SCHED_FIXED_PRIO_EN
         ptr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
         stl_q   <= stl_d;
         retry_q <= retry_d;
         en_q    <= en_d;
         act_q   <= act_d;
         flt_q   <= flt_d;
         safe_q  <= safe_d;
         busy_q  <= busy_d;
`ifndef PWR_SCHED_FIXED_PRIO_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign bus.dom_en         = en_q;
   assign bus.dom_active     = act_q;
   assign bus.dom_fault      = flt_q;
   assign bus.safe_state_req = safe_q;
   assign bus.busy           = busy_q;
   assign bus.fsm_state      = state_q;

endmodule

// File: tb/tb_pwr_domain_scheduler.sv
// Bench for pwr_domain_scheduler. A simple plant raises each domain's
// power-good a programmable number of cycles after its switch turns on.
// Stimulus plans each request batch from the scheduling rules (grant order,
// ramp/settle/retry durations) and queues the expected rising edges of
// dom_en / dom_active / dom_fault with their cycle numbers; a monitor pops
// and compares on every observed rising edge.
module tb_pwr_domain_scheduler;
   localparam int N_DOM     = 4;
   localparam int CNT_W     = 16;
   localparam int MAX_RETRY = 2;
   localparam int NEVER     = 1000;
   localparam int K_EN = 0, K_ACT = 1, K_FLT = 2;

   typedef struct {
      int kind;
      int idx;
      int cyc;
   } ev_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   ev_t  exp_q[$];
   int   dly[N_DOM];
   int   on_cnt[N_DOM];
   logic [N_DOM-1:0] pg_kill;
   int   rr_ptr = 0;

   pwr_domain_scheduler_if #(.N_DOM(N_DOM), .CNT_W(CNT_W)) bus();

   pwr_domain_scheduler #(.N_DOM(N_DOM), .CNT_W(CNT_W), .MAX_RETRY(MAX_RETRY)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // plant: on_cnt = cycles the switch has been on
   always @(posedge clk) begin
      for (int i = 0; i < N_DOM; i++) on_cnt[i] <= bus.dom_en[i] ? on_cnt[i] + 1 : 0;
   end
   always_comb begin
      bus.dom_pgood = '0;
      for (int i = 0; i < N_DOM; i++)
         bus.dom_pgood[i] = bus.dom_en[i] && (on_cnt[i] >= dly[i]) && !pg_kill[i];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic sb_pop(input int kind, input int idx);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL sb_unexpected: kind=%0d dom=%0d cycle=%0d, nothing expected", kind, idx, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.idx != idx || e.cyc != cyc) begin
            errors++;
            $display("FAIL sb_event: got kind=%0d dom=%0d cycle=%0d, expected kind=%0d dom=%0d cycle=%0d",
                     kind, idx, cyc, e.kind, e.idx, e.cyc);
         end
      end
   endtask

   task automatic drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d expected events not seen, next kind=%0d dom=%0d cycle=%0d",
                  name, exp_q.size(), exp_q[0].kind, exp_q[0].idx, exp_q[0].cyc);
         exp_q.delete();
      end
   endtask

   // monitor: rising edges of en/active/fault
   logic [N_DOM-1:0] p_en = '0, p_act = '0, p_flt = '0;
   always @(negedge clk) begin
      logic [N_DOM-1:0] r_en, r_act, r_flt;
      if (reset) begin
         p_en = '0; p_act = '0; p_flt = '0;
      end else begin
         r_en  = bus.dom_en & ~p_en;
         r_act = bus.dom_active & ~p_act;
         r_flt = bus.dom_fault & ~p_flt;
         if (r_en != '0) check("single_en_rise", 32'($countones(r_en)), 32'd1);
         for (int i = 0; i < N_DOM; i++) if (r_en[i])  sb_pop(K_EN, i);
         for (int i = 0; i < N_DOM; i++) if (r_act[i]) sb_pop(K_ACT, i);
         for (int i = 0; i < N_DOM; i++) if (r_flt[i]) sb_pop(K_FLT, i);
         p_en = bus.dom_en; p_act = bus.dom_active; p_flt = bus.dom_fault;
      end
   end

   function automatic ev_t mk(input int kind, input int idx, input int c);
      ev_t e;
      e.kind = kind; e.idx = idx; e.cyc = c;
      return e;
   endfunction

   // Plan a batch of simultaneous requests whose first grant appears at 'start'.
   task automatic plan(input logic [N_DOM-1:0] req, input int start, input int t, input int s,
                       output int endc);
      int order[$];
      int gc, e;
`ifdef PWR_SCHED_FIXED_PRIO_EN
      for (int i = 0; i < N_DOM; i++) if (req[i]) order.push_back(i);
`else
      for (int k = 0; k < N_DOM; k++) if (req[(rr_ptr + k) % N_DOM]) order.push_back((rr_ptr + k) % N_DOM);
      if (order.size() != 0) rr_ptr = (order[order.size()-1] + 1) % N_DOM;
`endif
      gc = start;
      e  = start - 1;
      foreach (order[j]) begin
         exp_q.push_back(mk(K_EN, order[j], gc));
         if (dly[order[j]] <= t) begin
            e = gc + dly[order[j]] + s + 2;
            exp_q.push_back(mk(K_ACT, order[j], e));
         end else begin
            for (int r = 1; r <= MAX_RETRY; r++) exp_q.push_back(mk(K_EN, order[j], gc + r * (t + 2)));
            e = gc + (MAX_RETRY + 1) * (t + 1) + MAX_RETRY;
            exp_q.push_back(mk(K_FLT, order[j], e));
         end
         gc = e + 1;
      end
      endc = e;
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic cleanup();
      bus.dom_req = '0;
      @(negedge clk);
      check("drop_all", {bus.dom_en, bus.dom_active}, 0);
      bus.fault_clr = 1'b1;
      @(negedge clk);
      bus.fault_clr = 1'b0;
      check("fault_clr_idle", bus.dom_fault, 0);
   endtask

   task automatic run_batch(input logic [N_DOM-1:0] req, input int t, input int s);
      int endc;
      logic [N_DOM-1:0] ea, ef;
      @(negedge clk);
      bus.timeout_cycles = CNT_W'(t);
      bus.settle_cycles  = CNT_W'(s);
      plan(req, cyc + 1, t, s, endc);
      bus.dom_req = req;
      wait_to(endc + 2);
      drained("batch_events");
      ea = '0; ef = '0;
      for (int i = 0; i < N_DOM; i++) if (req[i]) begin
         if (dly[i] <= t) ea[i] = 1'b1; else ef[i] = 1'b1;
      end
      check("batch_active", bus.dom_active, ea);
      check("batch_fault", bus.dom_fault, ef);
      check("batch_idle", {bus.busy, bus.safe_state_req, bus.fsm_state}, 0);
      cleanup();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int endc, g, t, s, sel;
      logic [N_DOM-1:0] req;
      bus.sched_en = 1'b1; bus.vdd_fault = 1'b0; bus.fault_clr = 1'b0;
      bus.dom_req = '0; bus.timeout_cycles = '0; bus.settle_cycles = '0;
      pg_kill = '0;
      for (int i = 0; i < N_DOM; i++) dly[i] = 0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", {bus.dom_en, bus.dom_active, bus.dom_fault,
                              bus.safe_state_req, bus.busy, bus.fsm_state}, 0);
      reset = 1'b0;
      @(negedge clk);
      check("post_reset_idle", {bus.dom_en, bus.busy, bus.fsm_state}, 0);

      // two domains in turn, pgood 5 cycles after enable
      for (int i = 0; i < N_DOM; i++) dly[i] = 5;
      run_batch(4'b0011, 20, 3);

      // stuck pgood: three ramp windows then sticky fault, no safe state
      dly[2] = NEVER;
      run_batch(4'b0100, 10, 0);

      // full contention, repeated
      for (int i = 0; i < N_DOM; i++) dly[i] = 2;
      run_batch(4'b1111, 5, 1);
      run_batch(4'b1111, 5, 1);

      // sched_en low blocks new grants
      @(negedge clk);
      bus.sched_en = 1'b0;
      bus.timeout_cycles = 16'd6; bus.settle_cycles = 16'd2;
      bus.dom_req = 4'b0001;
      repeat (4) @(negedge clk);
      check("sched_en_block", {bus.dom_en, bus.busy}, 0);
      plan(4'b0001, cyc + 1, 6, 2, endc);
      bus.sched_en = 1'b1;
      wait_to(endc + 2);
      drained("sched_en_events");
      check("sched_en_active", bus.dom_active, 4'b0001);
      cleanup();

      // randomized batches
      for (int b = 0; b < 24; b++) begin
         req = 4'($urandom_range(1, 15));
         t = $urandom_range(0, 12);
         s = $urandom_range(0, 4);
         for (int i = 0; i < N_DOM; i++) begin
            sel = $urandom_range(0, 4);
            case (sel)
               0: dly[i] = 0;
               1: dly[i] = t;
               2: dly[i] = t + 1;
               3: dly[i] = $urandom_range(0, t);
               default: dly[i] = NEVER;
            endcase
         end
         run_batch(req, t, s);
      end

      // brownout of an active domain
      for (int i = 0; i < N_DOM; i++) dly[i] = 2;
      @(negedge clk);
      bus.timeout_cycles = 16'd20; bus.settle_cycles = 16'd3;
      plan(4'b0101, cyc + 1, 20, 3, endc);
      bus.dom_req = 4'b0101;
      wait_to(endc + 2);
      drained("brownout_setup");
      pg_kill = 4'b0100;
      exp_q.push_back(mk(K_FLT, 2, cyc + 1));
      @(negedge clk);
      check("brownout_en", bus.dom_en, 4'b0001);
      check("brownout_active", bus.dom_active, 4'b0001);
      check("brownout_fault", bus.dom_fault, 4'b0100);
      check("brownout_state", {bus.safe_state_req, bus.fsm_state}, {1'b1, 3'd4});
      bus.dom_req = '0; pg_kill = '0; bus.fault_clr = 1'b1;
      @(negedge clk);
      bus.fault_clr = 1'b0;
      check("brownout_clr", {bus.safe_state_req, bus.fsm_state, bus.dom_fault}, 0);
      @(negedge clk);
      check("brownout_drop", bus.dom_en, 0);
      drained("brownout_events");

      // rail fault during SETTLE of dom1
      dly[1] = 3;
      @(negedge clk);
      bus.timeout_cycles = 16'd20; bus.settle_cycles = 16'd6;
      g = cyc + 1;
      plan(4'b0010, g, 20, 6, endc);
      bus.dom_req = 4'b0010;
      wait_to(g + 5);
      bus.vdd_fault = 1'b1;
      void'(exp_q.pop_back());
      @(negedge clk);
      check("vdd_safe", {bus.safe_state_req, bus.busy, bus.fsm_state}, {2'b10, 3'd4});
      check("vdd_outputs", {bus.dom_en, bus.dom_active}, 0);
      bus.fault_clr = 1'b1;
      @(negedge clk);
      check("vdd_clr_ignored", {bus.safe_state_req, bus.fsm_state}, {1'b1, 3'd4});
      bus.vdd_fault = 1'b0;
      plan(4'b0010, cyc + 2, 20, 6, endc);
      @(negedge clk);
      bus.fault_clr = 1'b0;
      check("vdd_exit", {bus.safe_state_req, bus.fsm_state}, 0);
      wait_to(endc + 2);
      drained("vdd_regrant");
      check("vdd_regrant_active", bus.dom_active, 4'b0010);
      cleanup();

      // request dropped mid-RAMP
      dly[3] = NEVER;
      @(negedge clk);
      bus.timeout_cycles = 16'd15; bus.settle_cycles = 16'd0;
      g = cyc + 1;
      plan(4'b1000, g, 15, 0, endc);
      bus.dom_req = 4'b1000;
      wait_to(g + 3);
      bus.dom_req = '0;
      exp_q.delete();
      @(negedge clk);
      check("drop_abort", {bus.dom_en, bus.busy, bus.fsm_state}, 0);
      check("drop_nofault", bus.dom_fault, 0);
      drained("drop_events");

      // reset mid-RAMP
      dly[0] = NEVER;
      @(negedge clk);
      g = cyc + 1;
      plan(4'b0001, g, 15, 0, endc);
      bus.dom_req = 4'b0001;
      wait_to(g + 2);
      check("pre_reset_busy", {bus.busy, bus.dom_en}, {1'b1, 4'b0001});
      reset = 1'b1;
      bus.dom_req = '0;
      exp_q.delete();
      @(negedge clk);
      check("reset_mid_ramp", {bus.dom_en, bus.dom_active, bus.dom_fault,
                               bus.safe_state_req, bus.busy, bus.fsm_state}, 0);
      reset = 1'b0;
      rr_ptr = 0;
      @(negedge clk);

      // after reset the round-robin order restarts at domain 0
      for (int i = 0; i < N_DOM; i++) dly[i] = 1;
      run_batch(4'b1111, 4, 0);
      run_batch(4'b1011, 4, 0);

      drained("final");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
